// File: rtl/serial_frame_writer_pkg.sv
// Shared definitions for the serial frame writer.
//   FRAME_LEN_DEF : bits per serial frame (bit index runs 0..FRAME_LEN-1)
//   DW_DEF        : width of a stored word (frame bits zero-extended)
//   DEPTH_DEF     : number of store entries
//   AW_DEF        : store address width
//   state_e       : capture FSM encoding
//   IDX_LAST      : index value of the final bit of a frame
package serial_frame_writer_pkg;

  localparam int FRAME_LEN_DEF = 10;
  localparam int DW_DEF        = 16;
  localparam int DEPTH_DEF     = 16;
  localparam int AW_DEF        = 4;

  localparam logic [3:0] IDX_LAST = 4'd9;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

endpackage

// File: rtl/serial_frame_writer_frame_store.sv
// DEPTH x DW register file holding completed frames.
//   clk, rst           : clock, async active-high reset (clears every entry)
//   wr_en, wr_addr,
//   wr_data            : single synchronous write port
//   rd_addr, rd_data   : combinational read port (old value during a write)
module serial_frame_writer_frame_store #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/serial_frame_writer.sv
// Reassembles 10-bit serial frames into parallel words, writes each word into
// a circular 16-entry store and offers it downstream over valid/ready.
//   clk, rst           : clock, async active-high reset
//   din                : serial bit, sampled each edge while capturing
//   start              : marks bit 0 of the first frame (ignored once capturing)
//   abort              : drop the partial frame and return to IDLE
//   frame_valid/ready  : downstream handshake for frame_data
//   frame_data         : last accepted-into-output frame, zero-extended
//   overrun, clr_ovr   : sticky "frame completed while output still pending"
//   wr_ptr             : next store entry to be written (wraps, no full flag)
//   rd_addr, rd_data   : combinational store read
module serial_frame_writer
  import serial_frame_writer_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DW        = DW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          start,
  input  logic          abort,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic [DW-1:0] frame_data,
  output logic          overrun,
  input  logic          clr_ovr,
  output logic [AW-1:0] wr_ptr,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [DW-1:0] asm_q, asm_d;
  logic          frame_valid_q, frame_valid_d;
  logic [DW-1:0] frame_data_q, frame_data_d;
  logic          overrun_q, overrun_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wr_en;
  logic [DW-1:0] word_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      asm_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      overrun_q     <= 1'b0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      overrun_q     <= overrun_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // The last bit is still on din at the completing edge, so the finished word
  // is the assembly register with din patched into the top frame bit.
  always_comb begin
    word_c                = asm_q;
    word_c[FRAME_LEN-1]   = din;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    asm_d         = asm_q;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    overrun_d     = overrun_q;
    wr_ptr_d      = wr_ptr_q;
    wr_en         = 1'b0;

    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
    // Clear first so a same-edge overrun event below overrides it.
    if (clr_ovr) begin
      overrun_d = 1'b0;
    end

    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      asm_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            asm_d    = '0;
            asm_d[0] = din;
            idx_d    = 4'd1;
            state_d  = CAPTURE;
          end
        end
        CAPTURE: begin
          if (idx_q == IDX_LAST) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            idx_d    = '0;
            asm_d    = '0;
            if (!frame_valid_q || frame_ready) begin
              frame_data_d  = word_c;
              frame_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            asm_d[idx_q] = din;
            idx_d        = idx_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign overrun     = overrun_q;
  assign wr_ptr      = wr_ptr_q;

  serial_frame_writer_frame_store #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_frame_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (word_c),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_serial_frame_writer.sv
module tb_serial_frame_writer;

  logic        clk;
  logic        rst;
  logic        din;
  logic        start;
  logic        abort;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_data;
  logic        overrun;
  logic        clr_ovr;
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  int total;
  int bad;

  serial_frame_writer dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .start       (start),
    .abort       (abort),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .overrun     (overrun),
    .clr_ovr     (clr_ovr),
    .wr_ptr      (wr_ptr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are checked there too.
  task automatic send_bit(input logic b, input logic s);
    din   = b;
    start = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Sends bits lo..hi of val, LSB first; start pulses with bit 0 if first=1.
  task automatic send_bits(input logic [9:0] val, input int lo, input int hi, input logic first);
    for (int i = lo; i <= hi; i++) begin
      send_bit(val[i], first && (i == 0));
    end
  endtask

  task automatic chk_mem(input string tag, input logic [3:0] a, input logic [15:0] exp);
    rd_addr = a;
    #1;
    chk(tag, {16'h0, rd_data}, {16'h0, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    din = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    frame_ready = 1'b1;
    clr_ovr = 1'b0;
    rd_addr = 4'd0;

    // Reset state
    #2;
    chk("rst_valid", frame_valid, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_wrptr", wr_ptr, 0);
    chk("rst_rd", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reference stream 1111110000 -> 0x3F, ready high
    send_bits(10'h03F, 0, 8, 1'b1);
    chk("ref_lat9_valid", frame_valid, 0);
    send_bits(10'h03F, 9, 9, 1'b0);
    chk("ref_f0_valid", frame_valid, 1);
    chk("ref_f0_data", frame_data, 16'h003F);
    chk("ref_f0_wrptr", wr_ptr, 1);
    chk_mem("ref_mem0", 4'd0, 16'h003F);
    send_bits(10'h03F, 0, 0, 1'b0);
    chk("ref_accept_drop", frame_valid, 0);
    send_bits(10'h03F, 1, 9, 1'b0);
    chk("ref_f1_valid", frame_valid, 1);
    chk("ref_f1_wrptr", wr_ptr, 2);
    chk_mem("ref_mem1", 4'd1, 16'h003F);

    // Backpressure
    do_reset();
    frame_ready = 1'b0;
    send_bits(10'h155, 0, 9, 1'b1);
    chk("bp_f0_data", frame_data, 16'h0155);
    chk("bp_f0_ovr", overrun, 0);
    send_bits(10'h155, 0, 9, 1'b0);
    chk("bp_f1_data", frame_data, 16'h0155);
    chk("bp_f1_ovr", overrun, 1);
    chk("bp_f1_wrptr", wr_ptr, 2);
    chk_mem("bp_mem0", 4'd0, 16'h0155);
    chk_mem("bp_mem1", 4'd1, 16'h0155);
    send_bits(10'h300, 0, 9, 1'b0);
    chk("bp_f2_held", frame_data, 16'h0155);
    chk("bp_f2_valid", frame_valid, 1);
    chk_mem("bp_mem2", 4'd2, 16'h0300);
    clr_ovr = 1'b1;
    send_bits(10'h201, 0, 0, 1'b0);
    clr_ovr = 1'b0;
    chk("bp_clr", overrun, 0);
    send_bits(10'h201, 1, 8, 1'b0);
    clr_ovr = 1'b1;
    send_bits(10'h201, 9, 9, 1'b0);
    clr_ovr = 1'b0;
    chk("bp_set_wins", overrun, 1);
    chk("bp_f3_wrptr", wr_ptr, 4);
    chk_mem("bp_mem3", 4'd3, 16'h0201);
    abort = 1'b1;
    send_bit(1'b0, 1'b0);
    abort = 1'b0;
    frame_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    chk("bp_accept_drop", frame_valid, 0);
    chk("bp_data_kept", frame_data, 16'h0155);

    // Wrap: 17 frames, frame n carries n
    do_reset();
    for (int n = 0; n < 17; n++) begin
      send_bits(10'(n), 0, 9, n == 0);
    end
    chk("wrap_wrptr", wr_ptr, 1);
    chk("wrap_data", frame_data, 16'h0010);
    chk("wrap_valid", frame_valid, 1);
    chk_mem("wrap_mem0", 4'd0, 16'h0010);
    chk_mem("wrap_mem1", 4'd1, 16'h0001);
    chk_mem("wrap_mem15", 4'd15, 16'h000F);

    // Abort at index 9, then din toggling in IDLE
    send_bits(10'h3FF, 0, 8, 1'b0);
    abort = 1'b1;
    send_bits(10'h3FF, 9, 9, 1'b0);
    abort = 1'b0;
    chk("abort_wrptr", wr_ptr, 1);
    chk_mem("abort_mem1", 4'd1, 16'h0001);
    for (int i = 0; i < 20; i++) begin
      send_bit(i[0], 1'b0);
    end
    chk("idle_wrptr", wr_ptr, 1);
    chk("idle_valid", frame_valid, 0);

    // Restart, with a stray start mid-frame
    send_bits(10'h2A5, 0, 3, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bits(10'h2A5, 5, 9, 1'b0);
    chk("start_mid_data", frame_data, 16'h02A5);
    chk("start_mid_wrptr", wr_ptr, 2);
    send_bits(10'h01C, 0, 9, 1'b0);
    chk("grid_data", frame_data, 16'h001C);
    chk("grid_wrptr", wr_ptr, 3);
    chk_mem("grid_mem1", 4'd1, 16'h02A5);
    chk_mem("grid_mem2", 4'd2, 16'h001C);

    // Async reset mid-frame, between edges
    send_bits(10'h3FF, 0, 4, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", frame_valid, 0);
    chk("arst_data", frame_data, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_wrptr", wr_ptr, 0);
    for (int a = 0; a < 16; a++) begin
      chk_mem("arst_mem", 4'(a), 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      send_bit(~i[0], 1'b0);
    end
    chk("arst_idle_wrptr", wr_ptr, 0);
    chk("arst_idle_valid", frame_valid, 0);
    chk_mem("arst_idle_mem0", 4'd0, 16'h0000);
    send_bits(10'h3FF, 0, 9, 1'b1);
    chk("arst_new_data", frame_data, 16'h03FF);
    chk("arst_new_wrptr", wr_ptr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_writer.md
Name: serial_frame_writer

Overview:
- Receiving end of the serial bit stream produced by the BCD-indexed ROM/16:1-mux path. One data bit is sampled per clock, with bit index running 0..9 like the BCD count.
- Each complete 10-bit frame is reassembled into a parallel word. The word is written into a 16-entry store and offered downstream over a valid/ready handshake.
- It is the writer counterpart to the existing read-only 16x16 memory.

Parameters:
- FRAME_LEN, 10, bits per frame; also the terminal index + 1 of the internal index counter.
- DW, 16, stored word width; frame bit i lands at word bit i, bits FRAME_LEN..DW-1 are zero.
- DEPTH, 16, number of store entries.
- AW, 4, address width, log2(DEPTH).

Ports:
- clk  input  1  single clock, all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit, sampled every posedge while capturing.
- start  input  1  frame-align pulse; marks the cycle carrying bit 0 of the first frame.
- abort  input  1  discard the partial frame and return to IDLE.
- frame_valid  output  1  a completed frame is held in frame_data.
- frame_ready  input  1  downstream accepts frame_data when frame_valid && frame_ready.
- frame_data  output  DW  last completed frame, zero-extended.
- overrun  output  1  sticky: a frame completed while frame_valid was still high.
- clr_ovr  input  1  synchronous clear of overrun.
- wr_ptr  output  AW  next store entry to be written.
- rd_addr  input  AW  store read address.
- rd_data  output  DW  combinational store read, mem[rd_addr].

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE, index=0, assembly register=0, all store entries=0.
  - frame_valid=0, frame_data=0, overrun=0, wr_ptr=0.
- FSM states: IDLE, CAPTURE.
- IDLE:
  - din is ignored.
  - start=1 at a posedge: sample din into assembly bit 0, index<=1, go to CAPTURE.
- CAPTURE:
  - Each posedge: assembly[index]<=din, then index<=index+1.
  - At index==FRAME_LEN-1, the complete word (assembly bits 0..8 plus the current din at bit 9) is formed combinationally. On that same edge:
    - write the word to mem[wr_ptr]; wr_ptr<=wr_ptr+1, wrapping 15->0 with no full flag (oldest entry is overwritten);
    - index<=0, assembly cleared;
    - stay in CAPTURE so frames run back-to-back with no gap.
  - start while in CAPTURE is ignored. Alignment is fixed by the first start.
- abort=1 at a posedge (either state):
  - go to IDLE, index=0, assembly cleared.
  - No store write, even if index==9 on that edge; abort has priority over completion.
- Frame completion handshake, evaluated on the completing edge:
  - If frame_valid=0, or frame_valid && frame_ready: frame_data<=word, frame_valid<=1.
  - If frame_valid && !frame_ready: frame_data is unchanged and overrun<=1. The store write still happens.
- Handshake outside completion:
  - frame_valid falls on the edge after acceptance (valid && ready) when no new frame completes on that edge.
  - frame_data is stable while frame_valid=1 and unaccepted.
- overrun:
  - Cleared by clr_ovr.
  - If clr_ovr and a new overrun event occur on the same edge, overrun stays 1 (set wins).
- Latency:
  - Bit 0 is sampled at edge E. frame_valid and the store entry are visible after edge E+9.
  - A new frame is presented every 10 cycles thereafter.
- rd_data is combinational. Reading the entry being written in the same cycle returns the old value.

Decomposition:
- Shared package holds:
  - FRAME_LEN, DW, DEPTH, AW defaults;
  - FSM state encoding (IDLE=1'b0, CAPTURE=1'b1);
  - the index terminal constant 4'd9.
- One natural sub-module, frame_store: DEPTH x DW register file with async clear, single write port, combinational read port.
- FSM, index counter, assembly register and handshake live in the top.

Test Plan:
- Reference stream: start with bit 0, then din pattern 1,1,1,1,1,1,0,0,0,0 repeated, frame_ready=1 -> frame_data=16'h003F after edge 10 and again every 10 cycles; mem[0]=mem[1]=16'h003F; wr_ptr increments per frame.
- Backpressure: frame_ready=0 for two frames of pattern 1,0,1,0,... -> frame_data stays 16'h0155; overrun=1 after the 2nd frame; mem[0] and mem[1] both hold 16'h0155. clr_ovr pulse -> overrun=0.
- Wrap: 17 frames where frame n has data n (LSB first) -> wr_ptr returns to 1; mem[0]=16'h0010 (frame 16 overwrote frame 0); mem[15]=16'h000F.
- Abort at index 9 -> no write, wr_ptr unchanged, state IDLE. din toggling in IDLE without start -> no writes.
- Async rst asserted mid-frame between clock edges -> all outputs zero immediately, rd_data=0 for every rd_addr; after deassertion nothing is captured until start.
- start asserted again mid-CAPTURE -> ignored; frame boundaries stay on the original 10-cycle grid.
